cache_refill_ctrl: RTL and testbench

- Memory-side miss handler for the direct-mapped word cache in the external-RAM pipeline.
- On a read miss or any store, it stalls the CPU, runs a req/ack transaction with external RAM, then writes the word and tag into the cache.
- Store policy is write-through with write-allocate.
- Sits between the pipeline MEM stage, the cache's hit output, and the external RAM port.

---
 rtl/cache_refill_ctrl_pkg.sv | 17 +
 rtl/cache_refill_ctrl_refill_fsm.sv | 73 +++++++
 rtl/cache_refill_ctrl.sv | 156 +++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_refill_ctrl_pkg.sv
// rtl/cache_refill_ctrl_pkg.sv - shared constants for the cache refill controller
// Contents: refill FSM state encoding, default WIDTH/DEPTH, word-align mask.
// Optional feature macro used by the top level: CACHE_REFILL_STATS_EN.
package cache_refill_ctrl_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // External RAM is word addressed; byte offset bits are always presented as 00.
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/cache_refill_ctrl_refill_fsm.sv
// rtl/cache_refill_ctrl_refill_fsm.sv - refill state machine and CPU stall generation
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   cpu_en_i/cpu_we_i MEM-stage access valid / access is a store
//   hit_i             cache tag compare result
//   mem_ack_i         external RAM completion strobe
//   state_o           current refill state
//   cpu_stall_o       pipeline freeze
//   latch_o           capture the CPU access this cycle (IDLE miss or store)
//   accept_o          RAM transaction completes this cycle (REQ with ack)
module cache_refill_ctrl_refill_fsm
    import cache_refill_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_en_i,
    input  logic       cpu_we_i,
    input  logic       hit_i,
    input  logic       mem_ack_i,
    output logic [1:0] state_o,
    output logic       cpu_stall_o,
    output logic       latch_o,
    output logic       accept_o
);

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       need_refill;

    // Stores always go to RAM (write-through); reads only on a tag miss.
    assign need_refill = cpu_en_i & (cpu_we_i | ~hit_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (need_refill) state_d = ST_REQ;
            ST_REQ:  if (mem_ack_i)   state_d = ST_FILL;
            ST_FILL: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cpu_stall_o = 1'b0;
        latch_o     = 1'b0;
        accept_o    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Stall must rise in the detecting cycle, so it is combinational.
                cpu_stall_o = need_refill;
                latch_o     = need_refill;
            end
            ST_REQ: begin
                cpu_stall_o = 1'b1;
                accept_o    = mem_ack_i;
            end
            ST_FILL: cpu_stall_o = 1'b1;
            default: cpu_stall_o = 1'b0;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - write-through/write-allocate miss handler for a direct-mapped word cache
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   cpu_en, cpu_we, cpu_addr,
//   cpu_wdata, cpu_stall        MEM-stage access and pipeline freeze
//   hit                         cache tag compare
//   cache_ena, cache_wena,
//   cache_addr, cache_wdata     cache RAM control (cache_wena also loads the tag)
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_ack,
//   mem_rdata                   external RAM req/ack port
// Optional (macro CACHE_REFILL_STATS_EN): miss_count, store_count completed-transaction counters.
module cache_refill_ctrl
    import cache_refill_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_en,
    input  logic             cpu_we,
    input  logic [31:0]      cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    input  logic             hit,
    output logic             cpu_stall,
    output logic             cache_ena,
    output logic             cache_wena,
    output logic [31:0]      cache_addr,
    output logic [WIDTH-1:0] cache_wdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
`ifdef CACHE_REFILL_STATS_EN
    ,
    output logic [31:0]      miss_count,
    output logic [31:0]      store_count
`endif
);

    // The index field (DEPTH bits above the byte offset) must fit in the address.
    if (DEPTH < 1 || DEPTH > 29) begin : g_depth_check
        $error("cache_refill_ctrl: DEPTH out of range");
    end

    logic [1:0]       state;
    logic             latch;
    logic             accept;

    logic [31:0]      addr_q,  addr_d;
    logic             we_q,    we_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] fill_q,  fill_d;

    cache_refill_ctrl_refill_fsm u_fsm (
        .clk         (clk),
        .rst         (rst),
        .cpu_en_i    (cpu_en),
        .cpu_we_i    (cpu_we),
        .hit_i       (hit),
        .mem_ack_i   (mem_ack),
        .state_o     (state),
        .cpu_stall_o (cpu_stall),
        .latch_o     (latch),
        .accept_o    (accept)
    );

    always_comb begin
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        fill_d  = fill_q;
        if (latch) begin
            addr_d  = cpu_addr;
            we_d    = cpu_we;
            wdata_d = cpu_wdata;
        end
        // Write-allocate: a store fills the cache with its own data, a read with RAM data.
        if (accept) begin
            fill_d = we_q ? wdata_q : mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            fill_q  <= '0;
        end else begin
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            fill_q  <= fill_d;
        end
    end

    // Request fields come straight from the latches, so they are stable for the whole REQ wait.
    assign mem_addr  = addr_q & WORD_ALIGN_MASK;
    assign mem_wdata = wdata_q;

    always_comb begin
        cache_ena   = 1'b0;
        cache_wena  = 1'b0;
        cache_addr  = addr_q;
        cache_wdata = fill_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        case (state)
            ST_IDLE: begin
                cache_ena  = cpu_en;
                cache_addr = cpu_addr;
            end
            ST_REQ: begin
                mem_req = 1'b1;
                mem_we  = we_q;
            end
            ST_FILL: begin
                cache_ena  = 1'b1;
                cache_wena = 1'b1;
            end
            default: cache_ena = 1'b1;
        endcase
    end

`ifdef CACHE_REFILL_STATS_EN
    logic [31:0] miss_count_q, miss_count_d;
    logic [31:0] store_count_q, store_count_d;

    always_comb begin
        miss_count_d  = miss_count_q;
        store_count_d = store_count_q;
        if (accept) begin
            if (we_q) store_count_d = store_count_q + 32'd1;
            else      miss_count_d  = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_count_q  <= '0;
            store_count_q <= '0;
        end else begin
            miss_count_q  <= miss_count_d;
            store_count_q <= store_count_d;
        end
    end

    assign miss_count  = miss_count_q;
    assign store_count = store_count_q;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - self-checking bench for cache_refill_ctrl
module tb_cache_refill_ctrl;

    localparam int WIDTH = 32;
    localparam int DEPTH = 3;
    localparam int NWAYS = 1 << DEPTH;

    logic             clk;
    logic             rst;
    logic             cpu_en;
    logic             cpu_we;
    logic [31:0]      cpu_addr;
    logic [WIDTH-1:0] cpu_wdata;
    logic             hit;
    logic             cpu_stall;
    logic             cache_ena;
    logic             cache_wena;
    logic [31:0]      cache_addr;
    logic [WIDTH-1:0] cache_wdata;
    logic             mem_req;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;
`ifdef CACHE_REFILL_STATS_EN
    logic [31:0]      miss_count;
    logic [31:0]      store_count;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_miss  = 0;
    int exp_store = 0;

    // Behavioural cache: tag is the full word address, index is the low DEPTH word bits.
    logic             valid_m [NWAYS];
    logic [29:0]      tag_m   [NWAYS];
    logic [WIDTH-1:0] data_m  [NWAYS];
    // Behavioural external RAM, word addressed.
    logic [WIDTH-1:0] mem_m [logic [29:0]];

    cache_refill_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_en      (cpu_en),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .hit         (hit),
        .cpu_stall   (cpu_stall),
        .cache_ena   (cache_ena),
        .cache_wena  (cache_wena),
        .cache_addr  (cache_addr),
        .cache_wdata (cache_wdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
`ifdef CACHE_REFILL_STATS_EN
        ,
        .miss_count  (miss_count),
        .store_count (store_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign hit = valid_m[cache_addr[DEPTH+1:2]] && (tag_m[cache_addr[DEPTH+1:2]] == cache_addr[31:2]);

    // The cache array writes word and tag on the negedge inside the write cycle.
    always @(negedge clk) begin
        if (cache_ena && cache_wena) begin
            valid_m[cache_addr[DEPTH+1:2]] <= 1'b1;
            tag_m[cache_addr[DEPTH+1:2]]   <= cache_addr[31:2];
            data_m[cache_addr[DEPTH+1:2]]  <= cache_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hit(input logic [31:0] a);
        return valid_m[a[DEPTH+1:2]] && (tag_m[a[DEPTH+1:2]] == a[31:2]);
    endfunction

    // One CPU access; ack arrives in REQ cycle lat+1. Expected stall = lat + 3 on a refill.
    task automatic do_access(input logic [31:0] a, input bit we, input logic [31:0] wd, input int lat);
        bit          miss;
        bit          done;
        bit          req_seen;
        int          stalls;
        int          fills;
        int          reqk;
        int          cyc;
        logic [31:0] exp_data;
        done = 0; req_seen = 0; stalls = 0; fills = 0; reqk = 0; cyc = 0;
        @(negedge clk);
        cpu_en = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; mem_ack = 1'b0;
        #1;
        miss = we || !model_hit(a);
        chk("detect_stall", cpu_stall, miss);
        chk("detect_cache_addr", cache_addr, a);
        if (!miss) begin
            chk("hit_no_req", mem_req, 0);
            return;
        end
        if (we) begin
            exp_data = wd;
        end else begin
            if (!mem_m.exists(a[31:2])) mem_m[a[31:2]] = $urandom;
            exp_data = mem_m[a[31:2]];
        end
        stalls = 1;
        while (!done && cyc < 60) begin
            @(negedge clk);
            #1;
            cyc++;
            // Inputs outside IDLE must be ignored; scramble them.
            cpu_addr = $urandom; cpu_we = $urandom_range(0, 1); cpu_wdata = $urandom;
            if (mem_req) begin
                reqk++;
                if (!req_seen) begin
                    chk("req_addr", mem_addr, {a[31:2], 2'b00});
                    chk("req_we", mem_we, we);
                    if (we) chk("req_wdata", mem_wdata, wd);
                    req_seen = 1;
                end
                if (reqk == lat + 1) begin
                    mem_ack = 1'b1;
                    mem_rdata = we ? $urandom : mem_m[a[31:2]];
                end else begin
                    mem_ack = 1'b0;
                    mem_rdata = $urandom;
                end
            end else begin
                mem_ack = 1'b0;
            end
            if (cache_wena) begin
                fills++;
                chk("fill_addr", cache_addr, a);
                chk("fill_data", cache_wdata, exp_data);
            end
            if (cpu_stall) begin
                stalls++;
            end else begin
                done = 1;
                chk("done_hit", hit, 1);
                chk("done_ena", cache_ena, 1);
                cpu_en = 1'b0;
                mem_ack = 1'b1;  // stale ack, must be ignored
            end
        end
        chk("refill_completes", done, 1);
        chk("stall_cycles", stalls, lat + 3);
        chk("fill_count", fills, 1);
        if (we) begin
            mem_m[a[31:2]] = wd;
            exp_store++;
        end else begin
            exp_miss++;
        end
        @(negedge clk);
        #1;
        chk("stale_ack_no_req", mem_req, 0);
        chk("stale_ack_no_stall", cpu_stall, 0);
        mem_ack = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NWAYS; i++) begin
            valid_m[i] = 1'b0; tag_m[i] = '0; data_m[i] = '0;
        end
        rst = 1'b1; cpu_en = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        #12;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_cache_wena", cache_wena, 0);
        chk("rst_stall", cpu_stall, 0);
        chk("rst_mem_addr", mem_addr, 0);
        @(negedge clk);
        rst = 1'b0;

        // Reset while a request is outstanding.
        @(negedge clk);
        cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        @(negedge clk);
        #1;
        chk("pre_rst_req", mem_req, 1);
        #2;
        cpu_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst_req", mem_req, 0);
        chk("async_rst_stall", cpu_stall, 0);
        chk("async_rst_wena", cache_wena, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_no_cache_write", valid_m[0], 0);
        do_access(32'h40, 0, 0, 1);

        // Read miss at 0x44, ack two cycles after the request rises.
        mem_m[30'h11] = 32'hDEADBEEF;
        do_access(32'h44, 0, 0, 2);
        chk("fill_word_0x44", data_m[1], 32'hDEADBEEF);

        // Consecutive read hits.
        do_access(32'h44, 0, 0, 0);
        do_access(32'h40, 0, 0, 0);
        do_access(32'h44, 0, 0, 0);
        @(negedge clk);
        cpu_en = 1'b0;

        // Store with ack in the first REQ cycle.
        do_access(32'h100, 1, 32'h12345678, 0);
        chk("store_cache_word", data_m[0], 32'h12345678);

        // Index conflict: 0x004 and 0x024 share index 1.
        do_access(32'h004, 0, 0, 0);
        do_access(32'h024, 0, 0, 1);
        chk("conflict_evicts", model_hit(32'h004), 0);
        do_access(32'h004, 0, 0, 0);

        // Randomized accesses against the reference models.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] ra;
            ra = ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
            do_access(ra, ($urandom_range(0, 2) == 0), $urandom, $urandom_range(0, 3));
        end
        @(negedge clk);
        cpu_en = 1'b0;

`ifdef CACHE_REFILL_STATS_EN
        #1;
        chk("miss_count", miss_count, exp_miss);
        chk("store_count", store_count, exp_store);
        rst = 1'b1;
        #1;
        chk("rst_miss_count", miss_count, 0);
        chk("rst_store_count", store_count, 0);
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
